// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: picks up to two result producers per cycle in
// round-robin order and broadcasts their tag/data on two registered CDB lanes.
module cdb_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NREQ   = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic [NREQ-1:0]        ReqValid,
  input  logic [NREQ*DATA_W-1:0] ReqTag,
  input  logic [NREQ*DATA_W-1:0] ReqData,
  output logic [NREQ-1:0]        ReqGrant,
  output logic                   CDBValid0,
  output logic                   CDBValid1,
  output logic [DATA_W-1:0]      CDBTag0,
  output logic [DATA_W-1:0]      CDBTag1,
  output logic [DATA_W-1:0]      CDBData0,
  output logic [DATA_W-1:0]      CDBData1,
  output logic [15:0]            ConflictCnt
);

  // The 2-bit pointer only covers four requesters.
  localparam int unsigned NumReq = 4;

  logic [1:0]        rr_ptr_q, rr_ptr_d;
  logic              valid0_q, valid0_d, valid1_q, valid1_d;
  logic [DATA_W-1:0] tag0_q, tag0_d, tag1_q, tag1_d;
  logic [DATA_W-1:0] data0_q, data0_d, data1_q, data1_d;
  logic [15:0]       cnt_q, cnt_d;

  logic       win0_found, win1_found;
  logic [1:0] win0_idx, win1_idx;
  logic       conflict;

  // Round-robin scan starting at rr_ptr; first two valid requesters win.
  always_comb begin
    logic [1:0] idx;
    idx        = '0;
    win0_found = 1'b0;
    win1_found = 1'b0;
    win0_idx   = '0;
    win1_idx   = '0;
    for (int k = 0; k < NumReq; k++) begin
      idx = rr_ptr_q + 2'(k);
      if (ReqValid[idx]) begin
        if (!win0_found) begin
          win0_found = 1'b1;
          win0_idx   = idx;
        end else if (!win1_found) begin
          win1_found = 1'b1;
          win1_idx   = idx;
        end
      end
    end
  end

  assign conflict = ($countones(ReqValid) > 2);

  // Grants are combinational and suppressed by reset or flush.
  always_comb begin
    ReqGrant = '0;
    if (!reset && !flush) begin
      if (win0_found) ReqGrant[win0_idx] = 1'b1;
      if (win1_found) ReqGrant[win1_idx] = 1'b1;
    end
  end

  // Next-state: lanes follow winners, idle lanes keep their last tag/data.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    valid0_d = 1'b0;
    valid1_d = 1'b0;
    tag0_d   = tag0_q;
    tag1_d   = tag1_q;
    data0_d  = data0_q;
    data1_d  = data1_q;
    cnt_d    = cnt_q;
    if (!flush) begin
      if (win0_found) begin
        valid0_d = 1'b1;
        tag0_d   = ReqTag[win0_idx*DATA_W +: DATA_W];
        data0_d  = ReqData[win0_idx*DATA_W +: DATA_W];
        rr_ptr_d = win0_idx + 2'd1;
      end
      if (win1_found) begin
        valid1_d = 1'b1;
        tag1_d   = ReqTag[win1_idx*DATA_W +: DATA_W];
        data1_d  = ReqData[win1_idx*DATA_W +: DATA_W];
        rr_ptr_d = win1_idx + 2'd1;
      end
      if (conflict && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q <= '0;
      valid0_q <= 1'b0;
      valid1_q <= 1'b0;
      tag0_q   <= '0;
      tag1_q   <= '0;
      data0_q  <= '0;
      data1_q  <= '0;
      cnt_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      valid0_q <= valid0_d;
      valid1_q <= valid1_d;
      tag0_q   <= tag0_d;
      tag1_q   <= tag1_d;
      data0_q  <= data0_d;
      data1_q  <= data1_d;
      cnt_q    <= cnt_d;
    end
  end

  assign CDBValid0   = valid0_q;
  assign CDBValid1   = valid1_q;
  assign CDBTag0     = tag0_q;
  assign CDBTag1     = tag1_q;
  assign CDBData0    = data0_q;
  assign CDBData1    = data1_q;
  assign ConflictCnt = cnt_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_cdb_arbiter;

  localparam int DW = 32;

  logic           clk = 1'b0;
  logic           reset, flush;
  logic [3:0]     req_valid;
  logic [4*DW-1:0] req_tag, req_data;
  logic [3:0]     grant;
  logic           v0, v1;
  logic [DW-1:0]  tag0, tag1, data0, data1;
  logic [15:0]    cnt;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 0;

  always #5 clk = ~clk;

  cdb_arbiter #(.DATA_W(DW), .NREQ(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .ReqValid    (req_valid),
    .ReqTag      (req_tag),
    .ReqData     (req_data),
    .ReqGrant    (grant),
    .CDBValid0   (v0),
    .CDBValid1   (v1),
    .CDBTag0     (tag0),
    .CDBTag1     (tag1),
    .CDBData0    (data0),
    .CDBData1    (data1),
    .ConflictCnt (cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model state
  int          m_rr;
  bit          m_v0, m_v1;
  logic [DW-1:0] m_t0, m_t1, m_d0, m_d1;
  int          m_cnt;

  // Ordered list of valid requesters, scanning from the pointer.
  function automatic void winners(input logic [3:0] v, input int rr, output int q[$]);
    q = {};
    for (int k = 0; k < 4; k++)
      if (v[(rr + k) % 4]) q.push_back((rr + k) % 4);
  endfunction

  function automatic logic [3:0] exp_grant();
    int q[$];
    logic [3:0] g;
    g = 4'b0;
    if (reset || flush) return g;
    winners(req_valid, m_rr, q);
    for (int i = 0; i < q.size() && i < 2; i++) g[q[i]] = 1'b1;
    return g;
  endfunction

  // Model update on each rising edge.
  always @(posedge clk) begin
    int q[$];
    if (reset) begin
      m_rr = 0; m_v0 = 0; m_v1 = 0; m_cnt = 0;
      m_t0 = '0; m_t1 = '0; m_d0 = '0; m_d1 = '0;
    end else if (flush) begin
      m_v0 = 0; m_v1 = 0;
    end else begin
      winners(req_valid, m_rr, q);
      m_v0 = (q.size() >= 1);
      m_v1 = (q.size() >= 2);
      if (m_v0) begin
        m_t0 = req_tag[q[0]*DW +: DW];
        m_d0 = req_data[q[0]*DW +: DW];
      end
      if (m_v1) begin
        m_t1 = req_tag[q[1]*DW +: DW];
        m_d1 = req_data[q[1]*DW +: DW];
      end
      if (q.size() > 0) m_rr = (q[(q.size() >= 2) ? 1 : 0] + 1) % 4;
      if (q.size() > 2 && m_cnt < 16'hFFFF) m_cnt++;
    end
  end

  // Compare DUT against model mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      check("grant", 64'(grant), 64'(exp_grant()));
      check("valid0", 64'(v0), 64'(m_v0));
      check("valid1", 64'(v1), 64'(m_v1));
      check("tag0", 64'(tag0), 64'(m_t0));
      check("tag1", 64'(tag1), 64'(m_t1));
      check("data0", 64'(data0), 64'(m_d0));
      check("data1", 64'(data1), 64'(m_d1));
      check("conflict_cnt", 64'(cnt), 64'(m_cnt));
      check("lane_order", 64'(!v0 && v1), 64'(0));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [DW-1:0] t, input logic [DW-1:0] d);
    req_tag[i*DW +: DW]  = t;
    req_data[i*DW +: DW] = d;
  endtask

  logic [4:0] vec_tbl [8];

  initial begin
    reset = 1'b1; flush = 1'b0; req_valid = 4'b0;
    req_tag = '0; req_data = '0;
    cyc();
    chk_en = 1;
    // Reset dominates flush and suppresses grants.
    req_valid = 4'b1111; flush = 1'b1;
    @(negedge clk); check("lit_grant_in_reset", 64'(grant), 64'h0);
    cyc();
    reset = 1'b0; flush = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, DW'(32'h10 + i), DW'(32'h1000 + i));
    set_req(2, 32'd7, 32'hAB);
    req_valid = 4'b0100;
    @(negedge clk); check("lit_single_grant", 64'(grant), 64'h4);
    cyc();
    req_valid = 4'b1001;
    @(negedge clk);
    check("lit_single_v0", 64'(v0), 64'h1);
    check("lit_single_tag0", 64'(tag0), 64'h7);
    check("lit_single_data0", 64'(data0), 64'hAB);
    check("lit_single_v1", 64'(v1), 64'h0);
    check("lit_wrap_grant", 64'(grant), 64'h9);
    cyc();
    req_valid = 4'b1000;
    @(negedge clk);
    check("lit_wrap_tag0", 64'(tag0), 64'h13);
    check("lit_wrap_tag1", 64'(tag1), 64'h10);
    check("lit_rr1_grant", 64'(grant), 64'h8);
    cyc();
    req_valid = 4'b1111;
    @(negedge clk); check("lit_all_grant_a", 64'(grant), 64'h3);
    cyc();
    @(negedge clk); check("lit_all_grant_b", 64'(grant), 64'hC);
    cyc();
    req_valid = 4'b0001;
    @(negedge clk);
    check("lit_cnt_two", 64'(cnt), 64'h2);
    check("lit_rr0_grant", 64'(grant), 64'h1);
    cyc();
    req_valid = 4'b0011; flush = 1'b1;
    @(negedge clk); check("lit_flush_grant", 64'(grant), 64'h0);
    cyc();
    flush = 1'b0;
    @(negedge clk);
    check("lit_flush_v0", 64'(v0), 64'h0);
    check("lit_flush_v1", 64'(v1), 64'h0);
    check("lit_post_flush_grant", 64'(grant), 64'h3);
    cyc();
    req_valid = 4'b0; reset = 1'b1;
    @(negedge clk);
    check("lit_dbl_tag0", 64'(tag0), 64'h11);
    check("lit_dbl_tag1", 64'(tag1), 64'h10);
    check("lit_reset_grant", 64'(grant), 64'h0);
    cyc();
    reset = 1'b0;
    @(negedge clk);
    check("lit_rst_v0", 64'(v0), 64'h0);
    check("lit_rst_tag0", 64'(tag0), 64'h0);
    check("lit_rst_data1", 64'(data1), 64'h0);
    check("lit_rst_cnt", 64'(cnt), 64'h0);
    // Duplicate tags pass through untouched.
    for (int i = 0; i < 4; i++) set_req(i, 32'd5, DW'(32'hD0 + i));
    req_valid = 4'b0110;
    cyc();
    req_valid = 4'b0;
    @(negedge clk);
    check("lit_dup_tag0", 64'(tag0), 64'h5);
    check("lit_dup_tag1", 64'(tag1), 64'h5);
    // Directed mix: {flush, valid}
    vec_tbl = '{5'b0_0101, 5'b0_1110, 5'b1_1111, 5'b0_1010,
                5'b0_0111, 5'b0_0000, 5'b1_0001, 5'b0_1011};
    for (int r = 0; r < 2; r++) begin
      foreach (vec_tbl[j]) begin
        for (int i = 0; i < 4; i++) set_req(i, DW'(32'h20 + 4*j + i), $urandom);
        flush     = vec_tbl[j][4];
        req_valid = vec_tbl[j][3:0];
        cyc();
      end
    end
    flush = 1'b0;
    // Drive the conflict counter into saturation.
    req_valid = 4'b0111;
    for (int c = 0; c < 65540; c++) begin
      for (int i = 0; i < 4; i++) set_req(i, $urandom, $urandom);
      cyc();
    end
    @(negedge clk); check("lit_cnt_sat", 64'(cnt), 64'hFFFF);
    cyc(); cyc();
    @(negedge clk); check("lit_cnt_hold", 64'(cnt), 64'hFFFF);
    req_valid = 4'b0;
    cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning the width of the result data and of the tag.
REQ-002 SHALL have parameter NREQ, default 4 (fixed), meaning the number of requesters: 0=ALU0, 1=ALU1, 2=Load, 3=LoadCache.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port flush, input, 1, synchronous pipeline flush (mispredict).
REQ-006 SHALL have port ReqValid, input, NREQ, result pending per requester.
REQ-007 SHALL have port ReqTag, input, NREQ*DATA_W, destination ROB tag per requester (requester i at bits [i*DATA_W +: DATA_W]).
REQ-008 SHALL have port ReqData, input, NREQ*DATA_W, result data per requester.
REQ-009 SHALL have port ReqGrant, output, NREQ, combinational; the result is accepted this cycle.
REQ-010 SHALL have ports CDBValid0/CDBValid1, output, 1 each, broadcast lane valid.
REQ-011 SHALL have ports CDBTag0/CDBTag1 and CDBData0/CDBData1, output, DATA_W each, broadcast tag/data.
REQ-012 SHALL have port ConflictCnt, output, 16, count of cycles with more than 2 valid unmasked requests.

Function
REQ-013 SHALL arbitrate up to 2 winners per cycle among requesters with ReqValid=1 using a 2-bit round-robin pointer rr_ptr.
REQ-014 SHALL scan in order rr_ptr, rr_ptr+1, rr_ptr+2, rr_ptr+3 (mod 4); the first valid requester wins lane 0 and the second wins lane 1.
REQ-015 SHALL assert ReqGrant[i] in the same cycle for each winner only; a requester holds ReqValid/ReqTag/ReqData stable until granted.
REQ-016 SHALL register the winners' tag/data onto the CDB lanes with 1-cycle latency: grant in cycle N -> CDBValid/CDBTag/CDBData in cycle N+1.
REQ-017 SHALL clear CDBValid1 when only one requester wins, clear both lanes when none wins, and hold the previous CDBTag/CDBData values on any lane whose valid is 0.
REQ-018 SHALL update rr_ptr to (index of the last winner + 1) mod 4 when at least one grant occurs; otherwise rr_ptr SHALL be unchanged.
REQ-019 SHALL guarantee that any continuously valid requester is granted within 2 cycles (no starvation).
REQ-020 SHALL, when flush=1, force ReqGrant=0, clear CDBValid0/1 at the next edge, and leave rr_ptr and ConflictCnt unchanged.
REQ-021 SHALL increment ConflictCnt when flush=0 and popcount(ReqValid)>2, saturating at 16'hFFFF with no wrap.
REQ-022 SHALL never drive CDBValid0=0 together with CDBValid1=1.
REQ-023 SHALL ignore requester tag values: duplicate tags SHALL be broadcast as given, with no checking.

Reset
REQ-024 SHALL, when reset=1 at a rising edge, set rr_ptr=0, CDBValid0/1=0, CDBTag0/1=0, CDBData0/1=0 and ConflictCnt=0.
REQ-025 SHALL force ReqGrant=0 while reset=1; reset SHALL take priority over flush.
REQ-026 SHALL, when reset is asserted mid-operation, drop the in-flight broadcasts with no partial lane outputs; requesters re-present their results after reset.

Verification
REQ-027 SHALL be covered by: after reset, ReqValid=4'b0100, tag=7, data=0xAB -> ReqGrant=4'b0100; next cycle CDBValid0=1, CDBTag0=7, CDBData0=0xAB, CDBValid1=0; rr_ptr=3.
REQ-028 SHALL be covered by: rr_ptr=0, ReqValid=4'b1111 held for 2 cycles -> grants 4'b0011 then 4'b1100; ConflictCnt increments by 2; rr_ptr returns to 0.
REQ-029 SHALL be covered by: rr_ptr=3, ReqValid=4'b1001 -> lane0=req3, lane1=req0; rr_ptr=1.
REQ-030 SHALL be covered by: flush=1 with ReqValid=4'b0011 -> ReqGrant=0; next cycle CDBValid0/1=0; rr_ptr unchanged.
REQ-031 SHALL be covered by: ConflictCnt preloaded to 16'hFFFE with 3 valid requests for 3 cycles -> ConflictCnt=16'hFFFF and it holds.
REQ-032 SHALL be covered by: reset asserted in the cycle after a double grant -> all outputs 0 at the next edge and ReqGrant=0 during reset.
